// File: rtl/truth_table_scanner.sv
// truth_table_scanner: stimulus-and-capture engine for characterizing a single-output gate.
// On start it walks every input vector 0 .. 2^N_IN-1 onto drive_o. It holds each vector for
// SETTLE+1 cycles and samples sense_i on the last edge of the hold. The captured truth table is
// published on table_out_o and compared against expected_i when the scan completes.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset; aborts any scan in progress
//   start_i      scan request, only honoured while idle
//   sense_i      output of the gate under test (same clock domain or combinational from drive_o)
//   expected_i   reference truth table, bit k = expected output for input vector k
//   drive_o      registered input vector presented to the gate
//   busy_o       high while a scan is in progress
//   done_o       single-cycle completion pulse
//   table_out_o  captured truth table of the most recent completed scan
//   match_o      table_out_o == expected_i, evaluated at completion
module truth_table_scanner #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     sense_i,
  input  logic [(1 << N_IN)-1:0]   expected_i,
  output logic [N_IN-1:0]          drive_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [(1 << N_IN)-1:0]   table_out_o,
  output logic                     match_o
);

  localparam int unsigned NumVec = 1 << N_IN;
  localparam int unsigned IdxW   = N_IN + 1;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q,    idx_d;
  logic [3:0]          cnt_q,    cnt_d;
  logic [NumVec-1:0]   shadow_q, shadow_d;
  logic [NumVec-1:0]   table_q,  table_d;
  logic                match_q,  match_d;
  logic                done_q,   done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    table_d  = table_q;
    match_d  = match_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        cnt_d = '0;
        if (start_i) begin
          state_d = StScan;
        end
      end
      StScan: begin
        if (cnt_q < 4'(SETTLE)) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = '0;
          shadow_d[idx_q[N_IN-1:0]] = sense_i;
          if (idx_q == IdxW'(NumVec - 1)) begin
            // Publish the shadow including the bit captured on this very edge.
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
            table_d = shadow_d;
            match_d = (shadow_d == expected_i);
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      table_q  <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      table_q  <= table_d;
      match_q  <= match_d;
      done_q   <= done_d;
    end
  end

  // idx_q is forced to zero whenever idle, so it doubles as the registered drive vector.
  assign drive_o     = idx_q[N_IN-1:0];
  assign busy_o      = (state_q == StScan);
  assign done_o      = done_q;
  assign table_out_o = table_q;
  assign match_o     = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner. Three instances cover N_IN=2/SETTLE=2 (AND or OR gate),
// N_IN=2/SETTLE=0 (AND gate) and N_IN=3/SETTLE=2 (majority gate).
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] tbl;
    logic       m;
  } exp_t;
  exp_t sb_q[$];

  // Instance A: N_IN=2, SETTLE=2, gate selectable
  logic       start_a;
  logic [3:0] exp_a;
  int         kind_a;
  logic [1:0] drive_a;
  logic       busy_a, done_a, match_a, sense_a;
  logic [3:0] table_a;
  assign sense_a = (kind_a == 0) ? (&drive_a) : (|drive_a);

  // Instance B: N_IN=2, SETTLE=0, AND gate
  logic       start_b;
  logic [3:0] exp_b;
  logic [1:0] drive_b;
  logic       busy_b, done_b, match_b, sense_b;
  logic [3:0] table_b;
  assign sense_b = &drive_b;

  // Instance C: N_IN=3, SETTLE=2, majority gate
  logic       start_c;
  logic [7:0] exp_c;
  logic [2:0] drive_c;
  logic       busy_c, done_c, match_c, sense_c;
  logic [7:0] table_c;
  assign sense_c = (drive_c[0] & drive_c[1]) | (drive_c[0] & drive_c[2]) |
                   (drive_c[1] & drive_c[2]);

  truth_table_scanner #(.N_IN(2), .SETTLE(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .sense_i(sense_a), .expected_i(exp_a),
    .drive_o(drive_a), .busy_o(busy_a), .done_o(done_a), .table_out_o(table_a),
    .match_o(match_a)
  );

  truth_table_scanner #(.N_IN(2), .SETTLE(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .sense_i(sense_b), .expected_i(exp_b),
    .drive_o(drive_b), .busy_o(busy_b), .done_o(done_b), .table_out_o(table_b),
    .match_o(match_b)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_c), .sense_i(sense_c), .expected_i(exp_c),
    .drive_o(drive_c), .busy_o(busy_c), .done_o(done_c), .table_out_o(table_c),
    .match_o(match_c)
  );

  // Observation mux so one scan task can check any instance.
  int         sel;
  logic [2:0] obs_drive;
  logic       obs_busy, obs_done, obs_match;
  logic [7:0] obs_table;
  always_comb begin
    obs_drive = {1'b0, drive_a};
    obs_busy  = busy_a;
    obs_done  = done_a;
    obs_match = match_a;
    obs_table = {4'b0, table_a};
    case (sel)
      1: begin
        obs_drive = {1'b0, drive_b};
        obs_busy  = busy_b;
        obs_done  = done_b;
        obs_match = match_b;
        obs_table = {4'b0, table_b};
      end
      2: begin
        obs_drive = drive_c;
        obs_busy  = busy_c;
        obs_done  = done_c;
        obs_match = match_c;
        obs_table = table_c;
      end
      default: ;
    endcase
  end

  // Result of the last completed scan per instance, for hold-during-scan checks.
  logic [7:0] last_tbl [3];
  logic       last_m   [3];

  // kind: 0 = AND, 1 = OR (2-input); 2 = 3-input majority
  function automatic logic gate_ref(input int kind, input int k);
    logic [2:0] v;
    v = k[2:0];
    case (kind)
      0:       return (v[1:0] == 2'b11);
      1:       return (v[1:0] != 2'b00);
      default: return ($countones(v) >= 2);
    endcase
  endfunction

  task automatic set_start(input int s, input logic val);
    case (s)
      0:       start_a = val;
      1:       start_b = val;
      default: start_c = val;
    endcase
  endtask

  // Push the expected result, launch a scan and check the whole timeline through done.
  task automatic do_scan(input int s, input int kind, input logic [7:0] exp_tbl, input string nm);
    int         nin, settle, nv, total;
    logic [7:0] tbl;
    exp_t       got_exp;
    nin    = (s == 2) ? 3 : 2;
    settle = (s == 1) ? 0 : 2;
    nv     = 1 << nin;
    total  = nv * (settle + 1);
    tbl    = '0;
    for (int k = 0; k < nv; k++) tbl[k] = gate_ref(kind, k);
    sb_q.push_back('{tbl: tbl, m: (tbl == exp_tbl)});
    sel = s;
    case (s)
      0: begin kind_a = kind; exp_a = exp_tbl[3:0]; end
      1: exp_b = exp_tbl[3:0];
      default: exp_c = exp_tbl;
    endcase
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    checks++;
    if (obs_busy !== 1'b1 || obs_drive !== 3'd0 || obs_done !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b drive=%0d done=%b, want busy=1 drive=0 done=0",
               nm, obs_busy, obs_drive, obs_done);
    end
    for (int e = 1; e <= total; e++) begin
      @(posedge clk); #1;
      if (e < total) begin
        checks++;
        if (obs_drive !== 3'(e / (settle + 1)) || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
          errors++;
          $display("FAIL %s edge %0d: drive=%0d busy=%b done=%b, want drive=%0d busy=1 done=0",
                   nm, e, obs_drive, obs_busy, obs_done, e / (settle + 1));
        end
        if (e == total / 2) begin
          checks++;
          if (obs_table !== last_tbl[s] || obs_match !== last_m[s]) begin
            errors++;
            $display("FAIL %s hold mid-scan: table=%b match=%b, want table=%b match=%b",
                     nm, obs_table, obs_match, last_tbl[s], last_m[s]);
          end
        end
      end else begin
        got_exp = sb_q.pop_front();
        checks++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_drive !== 3'd0) begin
          errors++;
          $display("FAIL %s done: done=%b busy=%b drive=%0d, want done=1 busy=0 drive=0",
                   nm, obs_done, obs_busy, obs_drive);
        end
        checks++;
        if (obs_table !== got_exp.tbl || obs_match !== got_exp.m) begin
          errors++;
          $display("FAIL %s result: table=%b match=%b, want table=%b match=%b",
                   nm, obs_table, obs_match, got_exp.tbl, got_exp.m);
        end
        last_tbl[s] = got_exp.tbl;
        last_m[s]   = got_exp.m;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (obs_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse width: done=%b one cycle later, want 0", nm, obs_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++;
      if (obs_drive !== 3'd0 || obs_busy !== 1'b0 || obs_done !== 1'b0 ||
          obs_table !== 8'd0 || obs_match !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: drive=%0d busy=%b done=%b table=%b match=%b, want all 0",
                 s, obs_drive, obs_busy, obs_done, obs_table, obs_match);
      end
      last_tbl[s] = '0;
      last_m[s]   = 1'b0;
    end
    rst = 1'b0;
  endtask

  task automatic test_and();
    do_scan(0, 0, 8'b1000, "and");
  endtask

  task automatic test_or_then_and();
    do_scan(0, 1, 8'b1000, "or");
    do_scan(0, 0, 8'b1000, "and_rescan");
  endtask

  task automatic test_back_to_back();
    exp_t got_exp;
    sel = 0;
    kind_a = 0;
    exp_a  = 4'b1000;
    sb_q.push_back('{tbl: 8'b1000, m: 1'b1});
    start_a = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
    end
    got_exp = sb_q.pop_front();
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || {4'b0, table_a} !== got_exp.tbl) begin
      errors++;
      $display("FAIL b2b first done: done=%b busy=%b table=%b, want done=1 busy=0 table=%b",
               done_a, busy_a, table_a, got_exp.tbl);
    end
    sb_q.push_back('{tbl: 8'b1000, m: 1'b1});
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b restart: busy=%b done=%b, want busy=1 done=0", busy_a, done_a);
    end
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e < 12) begin
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
          errors++;
          $display("FAIL b2b second scan edge %0d: done=%b busy=%b, want done=0 busy=1",
                   e, done_a, busy_a);
        end
      end
    end
    start_a = 1'b0;
    got_exp = sb_q.pop_front();
    checks++;
    if (done_a !== 1'b1 || {4'b0, table_a} !== got_exp.tbl || match_a !== got_exp.m) begin
      errors++;
      $display("FAIL b2b second done: done=%b table=%b match=%b, want done=1 table=%b match=%b",
               done_a, table_a, match_a, got_exp.tbl, got_exp.m);
    end
    @(posedge clk); #1;
    last_tbl[0] = 8'b1000;
    last_m[0]   = 1'b1;
  endtask

  task automatic test_reset_mid_scan();
    int seen_done;
    sel = 0;
    kind_a  = 0;
    exp_a   = 4'b1000;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (drive_a !== 2'd0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
        table_a !== 4'd0 || match_a !== 1'b0) begin
      errors++;
      $display("FAIL mid-scan reset: drive=%0d busy=%b done=%b table=%b match=%b, want all 0",
               drive_a, busy_a, done_a, table_a, match_a);
    end
    for (int s = 0; s < 3; s++) begin
      last_tbl[s] = '0;
      last_m[s]   = 1'b0;
    end
    seen_done = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1 || busy_a === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL aborted scan activity: %0d cycles with done/busy, want 0", seen_done);
    end
    do_scan(0, 0, 8'b1000, "after_reset");
  endtask

  task automatic test_settle0();
    do_scan(1, 0, 8'b1000, "settle0");
  endtask

  task automatic test_majority();
    do_scan(2, 2, 8'b11101000, "majority");
  endtask

  task automatic test_expected_change();
    sel = 0;
    exp_a = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (match_a !== last_m[0] || {4'b0, table_a} !== last_tbl[0]) begin
      errors++;
      $display("FAIL expected change: match=%b table=%b, want match=%b table=%b",
               match_a, table_a, last_m[0], last_tbl[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    exp_a = '0; exp_b = '0; exp_c = '0;
    kind_a = 0;
    sel = 0;
    test_reset();
    test_and();
    test_expected_change();
    test_or_then_and();
    test_back_to_back();
    test_reset_mid_scan();
    test_settle0();
    test_majority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
